// File: rtl/clk_reset_pkg.sv
// Shared state encoding, default parameters and widths for the clock/reset sequencer.
// Pure definitions: no latency, no flow control.
package clk_reset_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_STAGGER   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_HOLD_CYCLES    = 1024;
    localparam int DEF_STAGGER_CYCLES = 16;

    localparam int CNT_W  = 16;
    localparam int LOSS_W = 8;

    // Saturating increment: holds at all-ones rather than wrapping to zero.
    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/clk_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; latency STAGES clocks.
// No flow control; async active-high reset clears every stage to 0.
module clk_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_reset_sequencer.sv
// Sequences AXI and core reset release after MMCM lock has been stable; outputs registered
// from next state (one clock after each decision). No backpressure; rst_req is a one-cycle pulse.
module clk_reset_sequencer
    import clk_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic       clk_200,
    input  logic       reset,
    input  logic       mmcm_locked,
    input  logic       rst_req,
    output logic       axi_resetn,
    output logic       core_reset,
    output logic       clk_stable,
    output logic [7:0] lock_loss_cnt
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 2..65535");
    end
    if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > 255) begin : g_bad_stagger
        $error("STAGGER_CYCLES must be in 1..255");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    logic              locked_s;
    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              axi_resetn_q;
    logic              core_reset_q;
    logic              clk_stable_q;

    clk_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk_200),
        .rst_i (reset),
        .d_i   (mmcm_locked),
        .q_o   (locked_s)
    );

    // Lock loss is tested before rst_req so a coincident request cannot mask a lost lock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        if (state_q == ST_WAIT_LOCK) begin
            cnt_d = '0;
            if (locked_s) begin
                state_d = ST_HOLD;
            end
        end else if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            loss_d  = sat_inc(loss_q);
        end else if (rst_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_STAGGER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STAGGER: begin
                    if (cnt_q == STAGGER_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            loss_q       <= '0;
            axi_resetn_q <= 1'b0;
            core_reset_q <= 1'b1;
            clk_stable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            axi_resetn_q <= (state_d == ST_STAGGER) || (state_d == ST_RUN);
            core_reset_q <= (state_d != ST_RUN);
            clk_stable_q <= (state_d == ST_RUN);
        end
    end

    assign axi_resetn    = axi_resetn_q;
    assign core_reset    = core_reset_q;
    assign clk_stable    = clk_stable_q;
    assign lock_loss_cnt = loss_q;

endmodule
